// File: rtl/uart_rx_oversampled_pkg.sv
// Shared UART state encodings (common with the transmitter) and the default oversampling ratio.
package uart_rx_oversampled_pkg;

  localparam int OVERSAMPLE_DEFAULT = 16;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_START_BIT = 2'd1;
  localparam logic [1:0] ST_DATA_BITS = 2'd2;
  localparam logic [1:0] ST_STOP_BIT  = 2'd3;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// Both flops reset to RESET_VAL so an idle-high line stays quiet through reset.
module uart_rx_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_oversampled.sv
// 8N1 UART receiver sampling at OVERSAMPLE x baud; emits the byte with a one-cycle done strobe,
// or a one-cycle err strobe when the stop bit is sampled low.
module uart_rx_oversampled
  import uart_rx_oversampled_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 in,
  output logic [DATA_BITS-1:0] out,
  output logic                 done,
  output logic                 busy,
  output logic                 err
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] MID_START = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] BIT_END   = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

  logic                 rx_s;
  logic [1:0]           state;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;

  uart_rx_sync #(.RESET_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (in),
    .q   (rx_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      out     <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          busy <= 1'b0;
          if (en && !rx_s) begin
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ST_START_BIT;
          end
        end
        ST_START_BIT: begin
          // Half a bit in: a start bit that has already gone high was only a glitch.
          if (cnt == MID_START) begin
            cnt <= '0;
            if (!rx_s) begin
              bit_idx <= '0;
              state   <= ST_DATA_BITS;
            end else begin
              busy  <= 1'b0;
              state <= ST_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DATA_BITS: begin
          if (cnt == BIT_END) begin
            cnt   <= '0;
            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
            if (bit_idx == LAST_BIT) begin
              state <= ST_STOP_BIT;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_STOP_BIT: begin
          // Back to IDLE at mid-stop so a following start edge is caught without dead time.
          if (cnt == BIT_END) begin
            cnt   <= '0;
            busy  <= 1'b0;
            state <= ST_IDLE;
            if (rx_s) begin
              out  <= shreg;
              done <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Self-checking bench: serial frames are driven bit by bit and the received events are
// compared against a frame-level model (byte if enabled with good stop, error marker if stop low).
`timescale 1ns/1ps
module tb_uart_rx_oversampled;

  localparam int OS      = 16;
  localparam int ERR_EVT = 256;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       in;
  logic [7:0] out;
  logic       done;
  logic       busy;
  logic       err;

  uart_rx_oversampled #(.OVERSAMPLE(OS), .DATA_BITS(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .in   (in),
    .out  (out),
    .done (done),
    .busy (busy),
    .err  (err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int busy_cyc = 0;
  int got_q[$];
  int exp_q[$];

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
  endtask

  // Observed events: received byte value, or ERR_EVT for a framing error.
  always @(negedge clk) begin
    if (!rst) begin
      if (done || err) chk("strobe_excl", int'(done && err), 0);
      if (done) got_q.push_back(int'(out));
      if (err)  got_q.push_back(ERR_EVT);
      if (busy) busy_cyc++;
    end
  end

  // Reference: a frame only registers if the receiver was enabled at its start edge.
  task automatic model_frame(input logic [7:0] b, input logic stop_bit);
    if (en) exp_q.push_back(stop_bit ? int'(b) : ERR_EVT);
  endtask

  task automatic hold(input logic v, input int n);
    in = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    model_frame(b, stop_bit);
    hold(1'b0, OS);
    for (int i = 0; i < 8; i++) hold(b[i], OS);
    hold(stop_bit, OS);
    in = 1'b1;
  endtask

  task automatic check_events(input string tag);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0)
      chk({tag, "_evt"}, got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] b;
    logic       sb;
    int         gap;

    rst = 1'b1;
    en  = 1'b1;
    in  = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_out", int'(out), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(err), 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Single frame, plus busy duration of 9.5 bit periods
    busy_cyc = 0;
    send_frame(8'h55, 1'b1);
    hold(1'b1, OS);
    check_events("f55");
    chk("f55_out", int'(out), 'h55);
    chk("f55_busy_cycles", busy_cyc, OS * 19 / 2);

    // Back-to-back frames
    send_frame(8'hA3, 1'b1);
    send_frame(8'h0F, 1'b1);
    hold(1'b1, OS);
    check_events("b2b");

    // Short low glitch: busy for half a bit, then rejected
    busy_cyc = 0;
    hold(1'b0, 4);
    hold(1'b1, 2 * OS);
    chk("glitch_busy_cycles", busy_cyc, OS / 2);
    chk("glitch_busy_end", int'(busy), 0);
    check_events("glitch");

    // Framing error keeps previous byte
    send_frame(8'h3C, 1'b0);
    hold(1'b1, 2 * OS);
    check_events("ferr");
    chk("ferr_out_held", int'(out), 'h0F);

    // Reset mid-frame after 4 data bits of 0xFF
    hold(1'b0, OS);
    hold(1'b1, 4 * OS);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst_out", int'(out), 0);
    chk("midrst_busy", int'(busy), 0);
    rst = 1'b0;
    hold(1'b1, OS);
    send_frame(8'h81, 1'b1);
    hold(1'b1, OS);
    check_events("midrst");
    chk("midrst_out_after", int'(out), 'h81);

    // Disabled receiver ignores a frame
    en = 1'b0;
    busy_cyc = 0;
    send_frame(8'h77, 1'b1);
    hold(1'b1, OS);
    chk("en0_busy_cycles", busy_cyc, 0);
    check_events("en0");

    // en raised mid-frame (during the stop bit): that frame is not received, the next one is
    hold(1'b0, OS);
    for (int i = 0; i < 8; i++) hold(b_const77(i), OS);
    hold(1'b1, 6);
    en = 1'b1;
    hold(1'b1, OS);
    check_events("en_mid");
    send_frame(8'h77, 1'b1);
    hold(1'b1, OS);
    check_events("en_after");

    // Randomized frames: data, stop-bit validity, enable, inter-frame gap
    for (int k = 0; k < 24; k++) begin
      b  = 8'($urandom_range(0, 255));
      sb = ($urandom_range(0, 5) != 0);
      en = ($urandom_range(0, 4) != 0);
      send_frame(b, sb);
      check_events("rand");
      gap = sb ? $urandom_range(0, 20) : 2 * OS + $urandom_range(0, 10);
      hold(1'b1, gap);
    end
    hold(1'b1, 2 * OS);
    check_events("tail");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  function automatic logic b_const77(input int i);
    logic [7:0] v;
    v = 8'h77;
    return v[i];
  endfunction

endmodule
